coeff_frame_tx: RTL and testbench
=================================

# coeff_frame_tx

Frame transmitter for the filter-coefficient link. It snapshots five 16-bit ADC values and the fifteen 16-bit biquad coefficients (low, mid and high bands) into the 42-byte sync-prefixed frame that the coefficient decoder unpacks. It then emits the frame one byte at a time over a valid/ready byte stream to the serial link (SPI/UART) shifter. It sits between the filter bank and the link PHY and gives the MCU side a readback path for the live coefficient set.

## Interface
Parameters:
- SYNC_WORD, 16'hAA55, sync pattern sent as the first two bytes (MSB first).
- FRAME_BYTES, 42, total bytes per frame; fixed by the layout below and not meant to be overridden.

Ports:
- clk  input  1  single system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  frame request; sampled only in IDLE.
- adc_vals  input  80  adc0 in [79:64] down to adc4 in [15:0].
- coeffs  input  240  bands in the order low, mid, high. Each band is b0, b1, b2, a1, a2. low_b0 is in [239:224] and high_a2 is in [15:0].
- tx_byte  output  8  current frame byte.
- tx_valid  output  1  tx_byte is valid.
- tx_ready  input  1  the downstream stage accepts the byte when tx_valid && tx_ready.
- busy  output  1  a frame is in flight.
- done  output  1  one-cycle pulse after the last byte is accepted.

## Operation
Frame layout, 336 bits, sent MSB first (bit 335 is in byte 0):
- Bytes 0-1: SYNC_WORD.
- Bytes 2-11: adc_vals.
- Bytes 12-21: low coefficients.
- Bytes 22-31: mid coefficients.
- Bytes 32-41: high coefficients.
- Each 16-bit field is sent as its high byte first, then its low byte.

Datapath:
- A 336-bit shift register holds the frame.
- A 6-bit byte counter, byte_idx, runs 0..41.

FSM states:
- IDLE:
  - tx_valid=0, busy=0.
  - If start=1: load shift register = {SYNC_WORD, adc_vals, coeffs}; byte_idx=0; go to SEND.
- SEND:
  - tx_valid=1, busy=1, tx_byte = shift_reg[335:328].
  - On a handshake with byte_idx<41: shift left 8 and increment byte_idx.
  - On a handshake with byte_idx==41: go to IDLE and assert done for the next cycle.
  - With no handshake: hold all state.

Rules:
- Inputs are captured only at the load edge. Changes to adc_vals or coeffs during SEND do not affect the frame in flight.
- start is ignored while in SEND; it is not queued.
- tx_byte and tx_valid are registered. Once tx_valid=1, tx_byte stays stable until it is accepted (AXI-stream-style rule).
- tx_valid never deasserts without a handshake.
- The block does no arithmetic. Coefficients are passed as raw bit patterns, and their sign is preserved exactly.
- byte_idx never wraps. Reaching 41 always ends the frame.

## Timing
- Reset (reset_n=0, asynchronous): state=IDLE, tx_byte=8'h00, tx_valid=0, busy=0, done=0, byte_idx=0, shift register cleared.
- Reset mid-frame aborts immediately. The partial frame is discarded, and no done pulse is produced after reset releases.
- start sampled high at edge N:
  - tx_valid=1 and busy=1 from cycle N+1.
  - tx_byte=8'hAA in cycle N+1.
- With tx_ready held at 1: one byte per cycle, so bytes 0..41 appear in cycles N+1..N+42.
- Last handshake at cycle M:
  - In cycle M+1: done=1 for exactly one cycle, busy=0, tx_valid=0.
- start=1 in the done cycle (M+1) is accepted. The next frame's 0xAA appears at M+2, giving at most one idle cycle between back-to-back frames.
- A stall (tx_ready=0) adds exactly one cycle per stalled cycle. There is no byte loss and no duplication.
- Minimum frame time is 42 cycles of tx_valid plus one done cycle.

## Test plan
- Reset and idle: hold reset_n=0, then release with start=0 for 10 cycles -> tx_valid=0, busy=0, done=0, tx_byte=00 throughout.
- Full frame with tx_ready=1:
  - Stimulus: adc_vals = 0x0001_0002_0003_0004_0005; coeffs with low_b0=mid_b0=high_b0=0x4000 and all others 0x0000; pulse start.
  - Required bytes: AA 55 00 01 00 02 00 03 00 04 00 05, then 40 00 followed by 8×00 three times (once per band).
  - done pulses once, 43 cycles after start.
- Backpressure: drive tx_ready with a pseudo-random pattern -> the same 42 bytes arrive in order, and tx_byte is stable on every stall cycle.
- Input snapshot and start masking: change coeffs to 0xFFFF and pulse start at byte 10 -> the frame still carries the originally captured values, and no second frame starts.
- Back-to-back: assert start in the done cycle -> second frame's 0xAA appears one cycle later and carries the new inputs; negative coefficient 0x8001 is sent as bytes 80 01.
- Reset mid-frame: assert reset_n=0 at byte 20 -> outputs go to their reset values asynchronously, no done pulse follows, and the next start sends a complete frame from 0xAA.

Source files
------------

// File: rtl/coeff_frame_tx.sv
// rtl/coeff_frame_tx.sv - snapshots ADC values and biquad coefficients into a 42-byte sync-prefixed frame
// and streams it out MSB first over a valid/ready byte interface.
module coeff_frame_tx #(
  parameter logic [15:0] SYNC_WORD   = 16'hAA55,
  parameter int          FRAME_BYTES = 42
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [79:0]  adc_vals,
  input  logic [239:0] coeffs,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         done
);

  localparam int         FW       = FRAME_BYTES * 8;
  localparam logic [5:0] LAST_IDX = 6'(FRAME_BYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_n;
  logic [FW-1:0]   shift_reg, shift_n;
  logic [5:0]      byte_idx, idx_n;
  logic            done_n;

  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    idx_n   = byte_idx;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          shift_n = {SYNC_WORD, adc_vals, coeffs};
          idx_n   = 6'd0;
          state_n = SEND;
        end
      end
      SEND: begin
        // tx_valid is always high in SEND, so tx_ready alone marks a handshake
        if (tx_ready) begin
          if (byte_idx == LAST_IDX) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            shift_n = shift_reg << 8;
            idx_n   = byte_idx + 6'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state they describe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      byte_idx  <= 6'd0;
      done      <= 1'b0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      tx_byte   <= 8'h00;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      byte_idx  <= idx_n;
      done      <= done_n;
      tx_valid  <= (state_n == SEND);
      busy      <= (state_n == SEND);
      tx_byte   <= (state_n == SEND) ? shift_n[FW-1 -: 8] : 8'h00;
    end
  end

endmodule

// File: tb/tb_coeff_frame_tx.sv
// tb/tb_coeff_frame_tx.sv - self-checking bench for coeff_frame_tx: vector table, randomized backpressure,
// snapshot/masking, back-to-back and mid-frame reset sequences against a field-level frame model.
module tb_coeff_frame_tx;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [79:0]  adc_vals;
  logic [239:0] coeffs;
  logic [7:0]   tx_byte;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_bytes [42];
  logic [7:0] spec_bytes [42];
  logic [7:0] got [$];

  typedef struct {
    logic [79:0]  adc;
    logic [239:0] cf;
    int           pct;
    int           idx;
    logic [7:0]   exp;
  } vec_t;

  vec_t vecs [4];

  coeff_frame_tx dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .adc_vals (adc_vals),
    .coeffs   (coeffs),
    .tx_byte  (tx_byte),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame as a list of 16-bit fields, each sent high byte first
  function automatic void model(input logic [79:0] a, input logic [239:0] c);
    logic [15:0] f [21];
    f[0] = 16'hAA55;
    for (int i = 0; i < 5; i++)  f[1+i] = a[79-16*i -: 16];
    for (int i = 0; i < 15; i++) f[6+i] = c[239-16*i -: 16];
    for (int i = 0; i < 21; i++) begin
      exp_bytes[2*i]   = f[i][15:8];
      exp_bytes[2*i+1] = f[i][7:0];
    end
  endfunction

  function automatic logic [239:0] rand_coeffs();
    logic [239:0] c;
    for (int i = 0; i < 15; i++) c[239-16*i -: 16] = 16'($urandom_range(65535));
    return c;
  endfunction

  function automatic logic [79:0] rand_adc();
    logic [79:0] a;
    for (int i = 0; i < 5; i++) a[79-16*i -: 16] = 16'($urandom_range(65535));
    return a;
  endfunction

  task automatic start_frame(input logic [79:0] a, input logic [239:0] c);
    adc_vals = a;
    coeffs   = c;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("first_valid", tx_valid, 1);
    chk("first_busy", busy, 1);
    chk("first_byte", tx_byte, 8'hAA);
  endtask

  // Runs from the cycle after the load edge until done; returns cycle offset of done and stall count
  task automatic collect(input int pct, input int mask_at, input int reset_at,
                         output int done_k, output int stalls);
    logic [7:0] pbyte;
    bit pstall;
    bit masked;
    pbyte = 8'h00;
    pstall = 1'b0;
    masked = 1'b0;
    stalls = 0;
    done_k = -1;
    got.delete();
    for (int k = 0; k < 2000; k++) begin
      if (done) begin
        done_k = k;
        chk("done_valid_low", tx_valid, 0);
        chk("done_busy_low", busy, 0);
        return;
      end
      if (reset_at >= 0 && got.size() == reset_at) begin
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", tx_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_byte", tx_byte, 8'h00);
        chk("async_rst_done", done, 0);
        step();
        step();
        reset_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
          step();
          chk("post_rst_done", done, 0);
          chk("post_rst_valid", tx_valid, 0);
        end
        return;
      end
      if (pstall) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_byte", tx_byte, pbyte);
      end
      chk("inframe_valid", tx_valid, 1);
      chk("inframe_busy", busy, 1);
      if (!masked && mask_at >= 0 && got.size() == mask_at) begin
        masked   = 1'b1;
        coeffs   = '1;
        adc_vals = '1;
        start    = 1'b1;
      end
      tx_ready = ($urandom_range(99) < pct);
      pstall = !tx_ready;
      pbyte  = tx_byte;
      if (tx_ready) got.push_back(tx_byte);
      else stalls++;
      step();
      start = 1'b0;
    end
    errors++;
    $display("FAIL frame_timeout actual=no_done required=done");
  endtask

  task automatic check_frame(input int done_k, input int stalls);
    chk("frame_len", got.size(), 42);
    for (int i = 0; i < 42 && i < got.size(); i++) chk($sformatf("byte%0d", i), got[i], exp_bytes[i]);
    chk("frame_cycles", done_k, 42 + stalls);
  endtask

  initial begin
    int dk;
    int st;
    logic [239:0] c;
    logic [79:0]  a;

    spec_bytes[0] = 8'hAA;
    spec_bytes[1] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      spec_bytes[2+2*i] = 8'h00;
      spec_bytes[3+2*i] = 8'(i + 1);
    end
    for (int i = 12; i < 42; i++) spec_bytes[i] = ((i - 12) % 10 == 0) ? 8'h40 : 8'h00;

    c = '0;
    c[239:224] = 16'h4000;
    c[159:144] = 16'h4000;
    c[79:64]   = 16'h4000;
    vecs[0] = '{adc: 80'h0001_0002_0003_0004_0005, cf: c, pct: 100, idx: 12, exp: 8'h40};
    vecs[1] = '{adc: 80'h0001_0002_0003_0004_0005, cf: c, pct: 40,  idx: 22, exp: 8'h40};
    c = rand_coeffs();
    c[95:80] = 16'h8001;
    vecs[2] = '{adc: rand_adc(), cf: c, pct: 100, idx: 30, exp: 8'h80};
    a = rand_adc();
    a[79:64] = 16'h1234;
    vecs[3] = '{adc: a, cf: rand_coeffs(), pct: 70, idx: 3, exp: 8'h34};

    reset_n  = 1'b0;
    start    = 1'b0;
    tx_ready = 1'b0;
    adc_vals = '0;
    coeffs   = '0;
    step();
    step();
    chk("rst_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_byte", tx_byte, 8'h00);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_valid", tx_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_byte", tx_byte, 8'h00);
    end

    // Table frames run back-to-back: each start lands in the previous done cycle
    for (int v = 0; v < 4; v++) begin
      model(vecs[v].adc, vecs[v].cf);
      start_frame(vecs[v].adc, vecs[v].cf);
      collect(vecs[v].pct, -1, -1, dk, st);
      check_frame(dk, st);
      chk("vec_byte", got.size() > vecs[v].idx ? got[vecs[v].idx] : 8'hxx, vecs[v].exp);
      if (v == 0) begin
        chk("done_latency", dk, 42);
        for (int i = 0; i < 42 && i < got.size(); i++) chk("spec_byte", got[i], spec_bytes[i]);
      end
      if (v == 2) chk("neg_low_byte", got.size() > 31 ? got[31] : 8'hxx, 8'h01);
    end

    step();
    chk("after_done_quiet", done, 0);

    model(vecs[0].adc, vecs[0].cf);
    start_frame(vecs[0].adc, vecs[0].cf);
    collect(100, 10, -1, dk, st);
    check_frame(dk, st);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("masked_no_restart", tx_valid, 0);
    end

    start_frame(rand_adc(), rand_coeffs());
    collect(100, -1, 20, dk, st);
    chk("abort_no_done", dk, -1);
    model(vecs[3].adc, vecs[3].cf);
    start_frame(vecs[3].adc, vecs[3].cf);
    collect(60, -1, -1, dk, st);
    check_frame(dk, st);

    for (int r = 0; r < 4; r++) begin
      a = rand_adc();
      c = rand_coeffs();
      model(a, c);
      step();
      start_frame(a, c);
      collect($urandom_range(100, 20), -1, -1, dk, st);
      check_frame(dk, st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
